// File: rtl/mitchell_seq_ctrl.sv
// Sequential Mitchell logarithmic multiplier: one shared leading-one encoder
// walks a then b, then K/F are summed and the approximate product is formed.
module mitchell_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam int PW = 3 * W;

  typedef enum logic [2:0] {IDLE, ENC_A, ENC_B, SUM, OUT} state_t;

  state_t          state;
  logic [W-1:0]    a_r, b_r;
  logic            zero_r;
  logic [KW-1:0]   ka, kb;
  logic [W-2:0]    xa, xb;
  logic [KW:0]     k_sum;
  logic [W-1:0]    f_sum;

  logic [W-1:0]    enc_in;
  logic [KW-1:0]   enc_k;
  logic [KW-1:0]   sh_amt;
  logic [W-2:0]    enc_frac;
  logic [PW-1:0]   wide;
  logic [2*W-1:0]  prod;

  // The single priority encoder, fed by whichever operand is being encoded.
  always_comb begin
    enc_in = (state == ENC_B) ? b_r : a_r;
    enc_k  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (enc_in[i]) enc_k = KW'(i);
    end
    sh_amt   = KW'(W - 1) - enc_k;
    enc_frac = (W-1)'(enc_in << sh_amt);
  end

  always_comb begin
    if (!f_sum[W-1])
      wide = (PW'(f_sum) + (PW'(1) << (W - 1))) << k_sum;
    else
      wide = PW'(f_sum) << (k_sum + (KW+1)'(1));
    prod = (2*W)'(wide >> (W - 1));
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // OUT spends its first cycle registering the product, which is what makes
  // the transfer-to-out_valid latency four edges; handshake waits for out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      zero_r    <= 1'b0;
      ka        <= '0;
      kb        <= '0;
      xa        <= '0;
      xb        <= '0;
      k_sum     <= '0;
      f_sum     <= '0;
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            zero_r <= (a == '0) || (b == '0);
            state  <= ENC_A;
          end
        end
        ENC_A: begin
          ka    <= enc_k;
          xa    <= enc_frac;
          state <= ENC_B;
        end
        ENC_B: begin
          kb    <= enc_k;
          xb    <= enc_frac;
          state <= SUM;
        end
        SUM: begin
          k_sum <= {1'b0, ka} + {1'b0, kb};
          f_sum <= {1'b0, xa} + {1'b0, xb};
          state <= OUT;
        end
        OUT: begin
          if (!out_valid) begin
            p         <= zero_r ? '0 : prod;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
